interrupt_ack_sequencer: RTL and testbench

// - CPU-facing end of the in-service path. Raises INT toward the CPU when the priority

---
 rtl/interrupt_ack_sequencer_pkg.sv | 26 ++
 rtl/interrupt_ack_sequencer_priority_encoder.sv | 25 ++
 rtl/interrupt_ack_sequencer.sv | 145 ++++++++++++++
 tb/tb_interrupt_ack_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_ack_sequencer_pkg.sv
// Shared definitions for the interrupt acknowledge sequencer:
//   - IRQ_COUNT / LEVEL_W     : request vector width and encoded level width
//   - DEFAULT_SPURIOUS_LEVEL  : level reported when INTA#1 finds nothing pending
//   - ack_state_t             : handshake FSM state encoding
//   - make_vector()           : builds the 8086 vector byte {T7..T3, level}
package interrupt_ack_sequencer_pkg;

    localparam int IRQ_COUNT              = 8;
    localparam int LEVEL_W                = 3;
    localparam int DEFAULT_SPURIOUS_LEVEL = 7;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        INT_PENDING = 3'd1,
        ACK1        = 3'd2,
        WAIT2       = 3'd3,
        ACK2        = 3'd4,
        DONE        = 3'd5
    } ack_state_t;

    function automatic logic [7:0] make_vector(input logic [4:0]         base,
                                               input logic [LEVEL_W-1:0] level);
        return {base, level};
    endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_priority_encoder.sv
// priority_encoder_8to3: reduces a request vector to a binary level.
//   request : in  IRQ_COUNT  request bits (normally one-hot)
//   level   : out LEVEL_W    index of the lowest set bit (IR0 highest priority)
//   valid   : out 1          any request bit set
module priority_encoder_8to3
    import interrupt_ack_sequencer_pkg::*;
(
    input  logic [IRQ_COUNT-1:0] request,
    output logic [LEVEL_W-1:0]   level,
    output logic                 valid
);

    // Scan from the top down so the lowest set index is the last write.
    always_comb begin
        level = '0;
        valid = 1'b0;
        for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
            if (request[i]) begin
                level = LEVEL_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// interrupt_ack_sequencer: CPU-facing end of the in-service path.
// Raises INT, runs the two-pulse 8086 INTA handshake, pulses acknowledge
// with the frozen level, drives the vector on INTA#2 and, in AEOI mode,
// emits the end-of-interrupt clear mask when the handshake completes.
//   clock, reset_n              : system clock, async active-low reset
//   highest_priority_interrupt  : one-hot pending request (0 = none)
//   aeoi_mode                   : automatic EOI enable
//   vector_base                 : vector bits T7..T3
//   inta_n                      : asynchronous CPU acknowledge strobe
//   int_out                     : interrupt request to CPU
//   acknowledge / serviced_level: 1-cycle ISR set pulse and its one-hot level
//   end_of_interrupt            : 1-cycle AEOI clear mask
//   data_out / data_out_enable  : vector byte and bus drive enable
module interrupt_ack_sequencer
    import interrupt_ack_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int SPURIOUS_LEVEL = DEFAULT_SPURIOUS_LEVEL
)(
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [IRQ_COUNT-1:0] highest_priority_interrupt,
    input  logic                 aeoi_mode,
    input  logic [4:0]           vector_base,
    input  logic                 inta_n,
    output logic                 int_out,
    output logic                 acknowledge,
    output logic [IRQ_COUNT-1:0] serviced_level,
    output logic [IRQ_COUNT-1:0] end_of_interrupt,
    output logic [7:0]           data_out,
    output logic                 data_out_enable
);

    // inta_n synchronizer plus one delay flop for edge detection.
    // Flops reset to 1 so a released reset never looks like a falling edge.
    logic [SYNC_STAGES-1:0] inta_sync;
    logic                   inta_prev;
    logic                   inta_cur;
    logic                   fall;
    logic                   rise;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inta_sync <= '1;
            inta_prev <= 1'b1;
        end else begin
            inta_sync <= {inta_sync[SYNC_STAGES-2:0], inta_n};
            inta_prev <= inta_sync[SYNC_STAGES-1];
        end
    end

    assign inta_cur = inta_sync[SYNC_STAGES-1];
    assign fall     = inta_prev & ~inta_cur;
    assign rise     = ~inta_prev & inta_cur;

    logic [LEVEL_W-1:0] enc_level;
    logic               pending;

    priority_encoder_8to3 u_encoder (
        .request (highest_priority_interrupt),
        .level   (enc_level),
        .valid   (pending)
    );

    ack_state_t         state;
    logic [LEVEL_W-1:0] level_q;
    logic               aeoi_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            level_q          <= '0;
            aeoi_q           <= 1'b0;
            int_out          <= 1'b0;
            acknowledge      <= 1'b0;
            serviced_level   <= '0;
            end_of_interrupt <= '0;
            data_out         <= '0;
            data_out_enable  <= 1'b0;
        end else begin
            // Both pulses last one cycle unless re-armed below.
            acknowledge      <= 1'b0;
            end_of_interrupt <= '0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        // Unsolicited INTA: treat as INTA#1 with nothing pending.
                        level_q        <= LEVEL_W'(SPURIOUS_LEVEL);
                        serviced_level <= '0;
                        aeoi_q         <= aeoi_mode;
                        state          <= ACK1;
                    end else if (pending) begin
                        int_out <= 1'b1;
                        state   <= INT_PENDING;
                    end
                end
                INT_PENDING: begin
                    // The CPU edge wins over a simultaneous request withdrawal.
                    if (fall) begin
                        int_out <= 1'b0;
                        aeoi_q  <= aeoi_mode;
                        if (pending) begin
                            level_q        <= enc_level;
                            serviced_level <= IRQ_COUNT'(1) << enc_level;
                            acknowledge    <= 1'b1;
                        end else begin
                            level_q        <= LEVEL_W'(SPURIOUS_LEVEL);
                            serviced_level <= '0;
                        end
                        state <= ACK1;
                    end else if (!pending) begin
                        int_out <= 1'b0;
                        state   <= IDLE;
                    end
                end
                ACK1: begin
                    if (rise) state <= WAIT2;
                end
                WAIT2: begin
                    if (fall) begin
                        data_out        <= make_vector(vector_base, level_q);
                        data_out_enable <= 1'b1;
                        state           <= ACK2;
                    end
                end
                ACK2: begin
                    if (rise) begin
                        data_out_enable <= 1'b0;
                        data_out        <= '0;
                        if (aeoi_q && (serviced_level != '0))
                            end_of_interrupt <= serviced_level;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
module tb_interrupt_ack_sequencer;

    logic       clock;
    logic       reset_n;
    logic [7:0] hpi;
    logic       aeoi_mode;
    logic [4:0] vector_base;
    logic       inta_n;
    logic       int_out;
    logic       acknowledge;
    logic [7:0] serviced_level;
    logic [7:0] end_of_interrupt;
    logic [7:0] data_out;
    logic       data_out_enable;

    int checks = 0;
    int errors = 0;

    interrupt_ack_sequencer #(.SYNC_STAGES(2), .SPURIOUS_LEVEL(7)) dut (
        .clock                      (clock),
        .reset_n                    (reset_n),
        .highest_priority_interrupt (hpi),
        .aeoi_mode                  (aeoi_mode),
        .vector_base                (vector_base),
        .inta_n                     (inta_n),
        .int_out                    (int_out),
        .acknowledge                (acknowledge),
        .serviced_level             (serviced_level),
        .end_of_interrupt           (end_of_interrupt),
        .data_out                   (data_out),
        .data_out_enable            (data_out_enable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pulse monitor, sampled on the falling edge.
    int         ack_cnt = 0;
    int         eoi_cnt = 0;
    int         overlap_cnt = 0;
    int         unstable_cnt = 0;
    logic [7:0] ack_lvl = 8'h00;
    logic       prev_de = 1'b0;
    logic [7:0] prev_do = 8'h00;

    always @(negedge clock) begin
        if (acknowledge) begin
            ack_cnt = ack_cnt + 1;
            ack_lvl = serviced_level;
        end
        if (end_of_interrupt != 8'h00) eoi_cnt = eoi_cnt + 1;
        if (acknowledge && end_of_interrupt != 8'h00) overlap_cnt = overlap_cnt + 1;
        if (prev_de && data_out_enable && data_out !== prev_do) unstable_cnt = unstable_cnt + 1;
        prev_de = data_out_enable;
        prev_do = data_out;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Four low cycles on the pin, then released.
    task automatic inta_pulse();
        inta_n = 1'b0;
        tick(4);
        inta_n = 1'b1;
    endtask

    int a0, e0;

    initial begin
        reset_n     = 1'b0;
        inta_n      = 1'b1;
        hpi         = 8'h00;
        aeoi_mode   = 1'b0;
        vector_base = 5'b00000;
        tick(2);
        check("rst_int",  {31'd0, int_out}, 32'd0);
        check("rst_ack",  {31'd0, acknowledge}, 32'd0);
        check("rst_de",   {31'd0, data_out_enable}, 32'd0);
        check("rst_svc",  {24'd0, serviced_level}, 32'd0);
        check("rst_eoi",  {24'd0, end_of_interrupt}, 32'd0);
        check("rst_do",   {24'd0, data_out}, 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Normal handshake, AEOI off.
        a0 = ack_cnt; e0 = eoi_cnt;
        hpi = 8'h08; vector_base = 5'b01000; aeoi_mode = 1'b0;
        tick(2);
        check("n_int_up", {31'd0, int_out}, 32'd1);
        inta_pulse();
        check("n_int_dn", {31'd0, int_out}, 32'd0);
        check("n_svc",    {24'd0, serviced_level}, 32'h08);
        check("n_ackcnt", ack_cnt - a0, 32'd1);
        check("n_acklvl", {24'd0, ack_lvl}, 32'h08);
        hpi = 8'h00;
        tick(4);
        check("n_float",  {31'd0, data_out_enable}, 32'd0);
        inta_pulse();
        check("n_de",     {31'd0, data_out_enable}, 32'd1);
        check("n_vec",    {24'd0, data_out}, 32'h43);
        tick(3);
        check("n_de_off", {31'd0, data_out_enable}, 32'd0);
        tick(3);
        check("n_eoi",    eoi_cnt - e0, 32'd0);

        // AEOI on.
        a0 = ack_cnt; e0 = eoi_cnt;
        hpi = 8'h01; vector_base = 5'b11111; aeoi_mode = 1'b1;
        tick(2);
        inta_pulse();
        check("a_svc",    {24'd0, serviced_level}, 32'h01);
        hpi = 8'h00;
        tick(4);
        inta_pulse();
        check("a_vec",    {24'd0, data_out}, 32'hF8);
        tick(3);
        check("a_eoi_on", {24'd0, end_of_interrupt}, 32'h01);
        tick(1);
        check("a_eoi_off",{24'd0, end_of_interrupt}, 32'h00);
        tick(2);
        check("a_eoicnt", eoi_cnt - e0, 32'd1);
        check("a_ackcnt", ack_cnt - a0, 32'd1);

        // Spurious: request withdrawn in the cycle the synchronized fall appears.
        a0 = ack_cnt; e0 = eoi_cnt;
        hpi = 8'h04; vector_base = 5'b10101; aeoi_mode = 1'b1;
        tick(2);
        inta_n = 1'b0;
        tick(2);
        hpi = 8'h00;
        tick(2);
        inta_n = 1'b1;
        check("s_int_dn", {31'd0, int_out}, 32'd0);
        check("s_svc",    {24'd0, serviced_level}, 32'h00);
        tick(4);
        inta_pulse();
        check("s_vec",    {24'd0, data_out}, 32'hAF);
        tick(6);
        check("s_ackcnt", ack_cnt - a0, 32'd0);
        check("s_eoicnt", eoi_cnt - e0, 32'd0);

        // Multiple bits: lowest index wins; later request waits for DONE.
        a0 = ack_cnt;
        hpi = 8'h30; vector_base = 5'b01000; aeoi_mode = 1'b0;
        tick(2);
        inta_pulse();
        check("m_svc",    {24'd0, serviced_level}, 32'h10);
        check("m_acklvl", {24'd0, ack_lvl}, 32'h10);
        tick(4);
        hpi = 8'h02;
        tick(1);
        check("m_int_w2", {31'd0, int_out}, 32'd0);
        inta_pulse();
        check("m_vec",    {24'd0, data_out}, 32'h44);
        check("m_int_a2", {31'd0, int_out}, 32'd0);
        tick(3);
        check("m_int_dn", {31'd0, int_out}, 32'd0);
        tick(2);
        check("m_int_re", {31'd0, int_out}, 32'd1);
        check("m_ackcnt", ack_cnt - a0, 32'd1);
        hpi = 8'h00;
        tick(3);
        check("m_int_wd", {31'd0, int_out}, 32'd0);

        // Reset asserted during ACK2.
        a0 = ack_cnt; e0 = eoi_cnt;
        hpi = 8'h08; vector_base = 5'b01000; aeoi_mode = 1'b1;
        tick(2);
        inta_pulse();
        hpi = 8'h00;
        tick(4);
        inta_n = 1'b0;
        tick(4);
        check("r_de_on",  {31'd0, data_out_enable}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("r_de_off", {31'd0, data_out_enable}, 32'd0);
        check("r_do",     {24'd0, data_out}, 32'h00);
        check("r_svc",    {24'd0, serviced_level}, 32'h00);
        inta_n = 1'b1;
        tick(2);
        reset_n = 1'b1;
        tick(4);
        check("r_eoicnt", eoi_cnt - e0, 32'd0);
        check("r_ackcnt", ack_cnt - a0, 32'd1);
        hpi = 8'h40;
        tick(2);
        check("r_idle",   {31'd0, int_out}, 32'd1);
        hpi = 8'h00;
        tick(3);

        // Withdrawn request: 3 cycles of 8'h80 with no INTA.
        a0 = ack_cnt;
        hpi = 8'h80;
        tick(2);
        check("w_int_up", {31'd0, int_out}, 32'd1);
        tick(1);
        hpi = 8'h00;
        tick(2);
        check("w_int_dn", {31'd0, int_out}, 32'd0);
        check("w_ackcnt", ack_cnt - a0, 32'd0);

        // Unsolicited INTA while idle: spurious vector, no pulses.
        a0 = ack_cnt; e0 = eoi_cnt;
        vector_base = 5'b00110; aeoi_mode = 1'b1;
        inta_pulse();
        tick(4);
        inta_pulse();
        check("u_vec",    {24'd0, data_out}, 32'h37);
        tick(6);
        check("u_ackcnt", ack_cnt - a0, 32'd0);
        check("u_eoicnt", eoi_cnt - e0, 32'd0);

        check("overlap",  overlap_cnt, 32'd0);
        check("stable",   unstable_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
